// File: rtl/pasc_bus_pkg.sv
// Shared definitions for the remote-port bus arbiter: widths, FSM encodings,
// the error read value and the latched bus request payload.
package pasc_bus_pkg;

    localparam int unsigned BUS_DATA_WIDTH = 16;
    localparam int unsigned BUS_ADDR_WIDTH = 16;

    // Arbiter FSM encodings
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUS  = 1'b1;

    // Read data returned to a core when the watchdog terminates an access
    localparam logic [BUS_DATA_WIDTH-1:0] BUS_ERR_DATA = 16'hFFFF;

    // Request captured at grant time and replayed on the shared bus
    typedef struct packed {
        logic                      wr;
        logic [BUS_ADDR_WIDTH-1:0] addr;
        logic [BUS_DATA_WIDTH-1:0] wdata;
    } bus_req_t;

    // Index width that stays legal for a single requester
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/remote_bus_arbiter_if.sv
// Core-side remote ports plus the shared device bus, bundled as one interface.
//   core_addr/core_wren/core_rden/core_write_val : per-core requests (packed, core i at slice i)
//   core_ready/core_read_val                     : completion pulse and broadcast read data
//   bus_addr/bus_wren/bus_rden/bus_write_val     : shared bus request, held until bus_ack
//   bus_ack/bus_read_val                         : target completion and read data
//   bus_error                                    : sticky watchdog flag
// master = arbiter side, slave = cores/target side.
interface remote_bus_arbiter_if
    import pasc_bus_pkg::*;
#(
    parameter int unsigned NUM_CORES = 4
) ();

    logic [BUS_ADDR_WIDTH*NUM_CORES-1:0] core_addr;
    logic [NUM_CORES-1:0]                core_wren;
    logic [NUM_CORES-1:0]                core_rden;
    logic [BUS_DATA_WIDTH*NUM_CORES-1:0] core_write_val;
    logic [NUM_CORES-1:0]                core_ready;
    logic [BUS_DATA_WIDTH-1:0]           core_read_val;
    logic [BUS_ADDR_WIDTH-1:0]           bus_addr;
    logic                                bus_wren;
    logic                                bus_rden;
    logic [BUS_DATA_WIDTH-1:0]           bus_write_val;
    logic                                bus_ack;
    logic [BUS_DATA_WIDTH-1:0]           bus_read_val;
    logic                                bus_error;

    modport master (
        input  core_addr, core_wren, core_rden, core_write_val, bus_ack, bus_read_val,
        output core_ready, core_read_val, bus_addr, bus_wren, bus_rden, bus_write_val,
               bus_error
    );

    modport slave (
        output core_addr, core_wren, core_rden, core_write_val, bus_ack, bus_read_val,
        input  core_ready, core_read_val, bus_addr, bus_wren, bus_rden, bus_write_val,
               bus_error
    );

endinterface

// File: rtl/remote_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// searching upward and wrapping.
//   req         : request vector
//   ptr         : index where the search starts
//   grant_c     : one-hot winner
//   grant_idx_c : winner index
//   any_c       : at least one request present
module rr_arbiter
    import pasc_bus_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant_c,
    output logic [IW-1:0] grant_idx_c,
    output logic          any_c
);

    logic [IW-1:0] pos;

    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        any_c       = 1'b0;
        pos         = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = IW'((32'(ptr) + k) % N);
            if (!any_c && req[pos]) begin
                any_c       = 1'b1;
                grant_idx_c = pos;
                grant_c[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/remote_bus_arbiter.sv
// Round-robin arbiter funnelling N cores' remote accesses onto one shared
// request/ack bus, with a watchdog that completes hung accesses.
//   clk, reset : clock and asynchronous active-high reset
//   ifc        : core ports and shared bus (master side)
module remote_bus_arbiter
    import pasc_bus_pkg::*;
#(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    remote_bus_arbiter_if.master ifc
);

    localparam int unsigned IW = idx_width(NUM_CORES);
    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [0:0]           state_q, state_nxt;
    logic [NUM_CORES-1:0] req_c;
    logic [NUM_CORES-1:0] arb_grant_c;
    logic [IW-1:0]        arb_idx_c;
    logic                 arb_any_c;
    bus_req_t             new_req_c;
    bus_req_t             cur_q;
    logic [IW-1:0]        grant_q, ptr_q, ptr_nxt;
    logic [CW-1:0]        cnt_q;
    logic                 done_c, timeout_c;
    logic [NUM_CORES-1:0] ready_c;
    logic                 bus_wren_q, bus_rden_q, err_q;
    logic [BUS_DATA_WIDTH-1:0] read_val_q;

    logic [BUS_ADDR_WIDTH-1:0] addr_arr  [NUM_CORES];
    logic [BUS_DATA_WIDTH-1:0] wdata_arr [NUM_CORES];

    // Unpack the per-core buses
    for (genvar i = 0; i < NUM_CORES; i++) begin : g_split
        assign addr_arr[i]  = ifc.core_addr[BUS_ADDR_WIDTH*i +: BUS_ADDR_WIDTH];
        assign wdata_arr[i] = ifc.core_write_val[BUS_DATA_WIDTH*i +: BUS_DATA_WIDTH];
    end

    assign req_c = ifc.core_wren | ifc.core_rden;

    rr_arbiter #(.N(NUM_CORES)) u_rr (
        .req         (req_c),
        .ptr         (ptr_q),
        .grant_c     (arb_grant_c),
        .grant_idx_c (arb_idx_c),
        .any_c       (arb_any_c)
    );

    // wren wins when a core raises both strobes
    assign new_req_c = '{wr:    ifc.core_wren[arb_idx_c],
                         addr:  addr_arr[arb_idx_c],
                         wdata: wdata_arr[arb_idx_c]};

    assign ptr_nxt = (grant_q == IW'(NUM_CORES - 1)) ? '0 : grant_q + IW'(1);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_nxt;
    end

    // Next state, completion detect and the combinational ready pulse
    always_comb begin
        state_nxt = state_q;
        done_c    = 1'b0;
        timeout_c = 1'b0;
        ready_c   = '0;
        case (state_q)
            IDLE: begin
                if (arb_any_c) state_nxt = BUS;
            end
            BUS: begin
                // An ack on the last watchdog cycle still counts as a clean completion
                done_c    = ifc.bus_ack || (cnt_q == CNT_LAST);
                timeout_c = !ifc.bus_ack && (cnt_q == CNT_LAST);
                if (done_c) begin
                    state_nxt        = IDLE;
                    ready_c[grant_q] = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant latches, bus strobes, watchdog, read data and error flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_q      <= '0;
            grant_q    <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            bus_wren_q <= 1'b0;
            bus_rden_q <= 1'b0;
            read_val_q <= '0;
            err_q      <= 1'b0;
        end else if (state_q == IDLE) begin
            if (arb_any_c) begin
                cur_q      <= new_req_c;
                grant_q    <= arb_idx_c;
                cnt_q      <= '0;
                bus_wren_q <= new_req_c.wr;
                bus_rden_q <= !new_req_c.wr;
            end
        end else if (done_c) begin
            bus_wren_q <= 1'b0;
            bus_rden_q <= 1'b0;
            cnt_q      <= '0;
            ptr_q      <= ptr_nxt;
            if (!cur_q.wr) read_val_q <= ifc.bus_ack ? ifc.bus_read_val : BUS_ERR_DATA;
            if (timeout_c) err_q <= 1'b1;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign ifc.core_ready    = ready_c;
    assign ifc.core_read_val = read_val_q;
    assign ifc.bus_addr      = cur_q.addr;
    assign ifc.bus_write_val = cur_q.wdata;
    assign ifc.bus_wren      = bus_wren_q;
    assign ifc.bus_rden      = bus_rden_q;
    assign ifc.bus_error     = err_q;

endmodule
